amns_batch_control: RTL

Parametrised control sequencer for the AMNS Montgomery multiplier. It loads the constants M'0 and M from the shared BRAM once, then runs a batch of op_count_i products A_k·B_k through the FIOS core, writing each result to its own BRAM slot. Chained mode feeds each result back as the next A operand, for exponentiation-style sequences. It sits between the BRAM port and the operand registers and FIOS core, in the same slot as the single-shot top controller it supersedes.

---
 rtl/amns_batch_control_if.sv | 31 +++
 rtl/amns_batch_control.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/amns_batch_control_if.sv
// BRAM port and FIOS handshake shared between the batch sequencer (master)
// and the memory / multiplier datapath (slave).
interface amns_batch_control_if #(
   parameter int ADDR_W = 10,
   parameter int IDX_W  = 5
);
   logic              BRAM_en_o;
   logic              BRAM_we_o;
   logic [ADDR_W-1:0] BRAM_addr_o;
   logic [IDX_W-1:0]  res_word_idx_o;
   logic              FIOS_start_o;
   logic              FIOS_done_i;

   modport master (
      output BRAM_en_o,
      output BRAM_we_o,
      output BRAM_addr_o,
      output res_word_idx_o,
      output FIOS_start_o,
      input  FIOS_done_i
   );

   modport slave (
      input  BRAM_en_o,
      input  BRAM_we_o,
      input  BRAM_addr_o,
      input  res_word_idx_o,
      input  FIOS_start_o,
      output FIOS_done_i
   );
endinterface

// File: rtl/amns_batch_control.sv
// Batch sequencer for the AMNS Montgomery multiplier: loads M'0/M once, then
// streams K operand pairs through the FIOS core and stores each result.
module amns_batch_control #(
   parameter int s        = 5,
   parameter int N        = 5,
   parameter int RD_LAT   = 2,
   parameter int MAX_OPS  = 8,
   parameter int ADDR_W   = 10,
   parameter int RES_BASE = 512,
   localparam int W       = N * s,
   localparam int IDX_W   = (W > 1) ? $clog2(W) : 1,
   localparam int OPC_W   = $clog2(MAX_OPS + 1),
   localparam int OPI_W   = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1
) (
   input  logic                  clock_i,
   input  logic                  reset_n_i,
   input  logic                  start_i,
   input  logic                  reload_const_i,
   input  logic                  chain_i,
   input  logic [OPC_W-1:0]      op_count_i,
   output logic                  M_prime_0_reg_en_o,
   output logic                  M_reg_en_o,
   output logic                  A_reg_en_o,
   output logic                  B_reg_en_o,
   output logic                  A_res_load_o,
   output logic [OPI_W-1:0]      op_idx_o,
   output logic                  busy_o,
   output logic                  done_o,
   amns_batch_control_if.master  bus
);

   localparam int C = N + W;

   generate
      if ((N + W + 2 * MAX_OPS * W > RES_BASE) ||
          (RES_BASE + MAX_OPS * W > (1 << ADDR_W)) ||
          (RD_LAT < 1) || (N < 1) || (s < 1) || (MAX_OPS < 1)) begin : g_paramCheck
         $error("amns_batch_control: parameters violate the BRAM memory map");
      end
   endgenerate

   typedef enum logic [3:0] {
      IDLE,
      LOAD_MP0,
      LOAD_M,
      LOAD_A,
      LOAD_B,
      DRAIN,
      FIOS_START,
      FIOS_WAIT,
      STORE_RES,
      NEXT,
      DONE
   } state_e;

   state_e                   r_state;
   state_e                   w_nextState;
   logic [ADDR_W-1:0]        r_offset;
   logic [ADDR_W-1:0]        r_opBase;
   logic [ADDR_W-1:0]        r_resBase;
   logic [OPI_W-1:0]         r_k;
   logic [OPC_W-1:0]         r_count;
   logic                     r_chain;
   logic                     r_constValid;
   logic [RD_LAT-1:0][3:0]   r_enPipe;

   logic [OPC_W-1:0]         w_kSat;
   logic                     w_lastOp;
   logic                     w_accept;
   logic                     w_bramEn;
   logic                     w_bramWe;
   logic                     w_fiosStart;
   logic                     w_aResLoad;
   logic                     w_busy;
   logic                     w_done;
   logic [3:0]               w_enIssue;
   logic [ADDR_W-1:0]        w_regionBase;

   assign w_kSat   = (op_count_i > OPC_W'(MAX_OPS)) ? OPC_W'(MAX_OPS) : op_count_i;
   assign w_lastOp = (OPC_W'(r_k) + OPC_W'(1)) == r_count;
   assign w_accept = (r_state == IDLE) && start_i;

   // Next-state and per-state control; every state exit is also the offset reset point.
   always_comb begin
      w_nextState  = r_state;
      w_bramEn     = 1'b0;
      w_bramWe     = 1'b0;
      w_fiosStart  = 1'b0;
      w_aResLoad   = 1'b0;
      w_busy       = 1'b1;
      w_done       = 1'b0;
      w_enIssue    = 4'b0000;
      w_regionBase = '0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (start_i) begin
               if (w_kSat == '0)
                  w_nextState = DONE;
               else if (reload_const_i || !r_constValid)
                  w_nextState = LOAD_MP0;
               else
                  w_nextState = LOAD_A;
            end
         end
         LOAD_MP0: begin
            w_bramEn     = 1'b1;
            w_enIssue    = 4'b1000;
            w_regionBase = '0;
            if (r_offset == ADDR_W'(N - 1)) w_nextState = LOAD_M;
         end
         LOAD_M: begin
            w_bramEn     = 1'b1;
            w_enIssue    = 4'b0100;
            w_regionBase = ADDR_W'(N);
            if (r_offset == ADDR_W'(W - 1)) w_nextState = LOAD_A;
         end
         LOAD_A: begin
            w_bramEn     = 1'b1;
            w_enIssue    = 4'b0010;
            w_regionBase = r_opBase;
            if (r_offset == ADDR_W'(W - 1)) w_nextState = LOAD_B;
         end
         LOAD_B: begin
            w_bramEn     = 1'b1;
            w_enIssue    = 4'b0001;
            w_regionBase = r_opBase + ADDR_W'(W);
            if (r_offset == ADDR_W'(W - 1)) w_nextState = DRAIN;
         end
         DRAIN: begin
            if (r_offset == ADDR_W'(RD_LAT - 1)) w_nextState = FIOS_START;
         end
         FIOS_START: begin
            w_fiosStart = 1'b1;
            w_nextState = FIOS_WAIT;
         end
         FIOS_WAIT: begin
            if (bus.FIOS_done_i) w_nextState = STORE_RES;
         end
         STORE_RES: begin
            w_bramEn     = 1'b1;
            w_bramWe     = 1'b1;
            w_regionBase = r_resBase;
            if (r_offset == ADDR_W'(W - 1)) w_nextState = NEXT;
         end
         NEXT: begin
            if (w_lastOp) begin
               w_nextState = DONE;
            end else if (r_chain) begin
               w_aResLoad  = 1'b1;
               w_nextState = LOAD_B;
            end else begin
               w_nextState = LOAD_A;
            end
         end
         DONE: begin
            w_done      = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_busy      = 1'b0;
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_offset <= '0;
      end else if (w_nextState != r_state) begin
         r_offset <= '0;
      end else begin
         r_offset <= r_offset + ADDR_W'(1);
      end
   end

   // Operand and result region bases advance together so address generation stays an add.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_opBase  <= '0;
         r_resBase <= '0;
         r_k       <= '0;
         r_count   <= '0;
         r_chain   <= 1'b0;
      end else if (w_accept) begin
         r_opBase  <= ADDR_W'(C);
         r_resBase <= ADDR_W'(RES_BASE);
         r_k       <= '0;
         r_count   <= w_kSat;
         r_chain   <= chain_i;
      end else if ((r_state == NEXT) && !w_lastOp) begin
         r_opBase  <= r_opBase + ADDR_W'(2 * W);
         r_resBase <= r_resBase + ADDR_W'(W);
         r_k       <= r_k + OPI_W'(1);
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_constValid <= 1'b0;
      end else if ((r_state == LOAD_M) && (w_nextState == LOAD_A)) begin
         r_constValid <= 1'b1;
      end
   end

   // Register enables trail their read address by exactly the BRAM latency.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_enPipe <= '0;
      end else begin
         r_enPipe[0] <= w_enIssue;
         for (int i = 1; i < RD_LAT; i++) begin
            r_enPipe[i] <= r_enPipe[i-1];
         end
      end
   end

   assign M_prime_0_reg_en_o = r_enPipe[RD_LAT-1][3];
   assign M_reg_en_o         = r_enPipe[RD_LAT-1][2];
   assign A_reg_en_o         = r_enPipe[RD_LAT-1][1];
   assign B_reg_en_o         = r_enPipe[RD_LAT-1][0];
   assign A_res_load_o       = w_aResLoad;
   assign op_idx_o           = r_k;
   assign busy_o             = w_busy;
   assign done_o             = w_done;

   assign bus.BRAM_en_o      = w_bramEn;
   assign bus.BRAM_we_o      = w_bramWe;
   assign bus.BRAM_addr_o    = w_bramEn ? (w_regionBase + r_offset) : '0;
   assign bus.res_word_idx_o = (r_state == STORE_RES) ? r_offset[IDX_W-1:0] : '0;
   assign bus.FIOS_start_o   = w_fiosStart;

endmodule
